// File: rtl/serdes_pkg.sv
// Shared encodings and widths for the SERDES receive link controller.
package serdes_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [7:0] SYNC_WORD_DEF = 8'hA5;

    localparam int BIT_CNT_W  = 3;
    localparam int BYTE_IDX_W = 4;
    localparam int HIT_CNT_W  = 3;
    localparam int MISS_CNT_W = 3;

    // Frame position after a completed byte: 1..last, then back to the sync slot 0.
    function automatic logic [BYTE_IDX_W-1:0] frame_idx_adv(
        input logic [BYTE_IDX_W-1:0] idx,
        input logic [BYTE_IDX_W-1:0] last
    );
        logic [BYTE_IDX_W-1:0] nxt;
        if (idx == last) begin
            nxt = 4'd0;
        end else begin
            nxt = idx + 4'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/serdes_deser_shift.sv
// Serial-to-parallel shifter with a bit counter that can be re-aligned to a byte boundary.
module serdes_deser_shift
    import serdes_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       shift_en,
    input  logic       align,
    input  logic       bit_in,
    output logic [7:0] shreg_next,
    output logic       byte_done
);

    logic [7:0]           shreg_r;
    logic [BIT_CNT_W-1:0] bit_cnt_r;

    // Next shift value and the strobe for the 8th bit of an aligned byte.
    always_comb begin
        shreg_next = {shreg_r[6:0], bit_in};
        byte_done  = shift_en && (bit_cnt_r == 3'd7);
    end

    // Shift register and bit position; align makes the next bit bit 0 of a byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_r   <= 8'd0;
            bit_cnt_r <= 3'd0;
        end else if (shift_en) begin
            shreg_r   <= shreg_next;
            bit_cnt_r <= align ? 3'd0 : bit_cnt_r + 3'd1;
        end else begin
            shreg_r   <= shreg_r;
            bit_cnt_r <= bit_cnt_r;
        end
    end

endmodule

// File: rtl/serdes_sync_ctrl.sv
// Receive link controller: hunts for the sync word, verifies frame alignment,
// declares lock/loss and emits aligned payload bytes with start-of-frame marking.
module serdes_sync_ctrl
    import serdes_pkg::*;
#(
    parameter logic [7:0]  SYNC_WORD = SYNC_WORD_DEF,
    parameter int unsigned FRAME_LEN = 4,
    parameter int unsigned LOCK_CNT  = 3,
    parameter int unsigned LOSS_CNT  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       bit_in,
    input  logic       bit_valid,
    input  logic       clear_err,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       byte_sof,
    output logic       locked,
    output logic [1:0] state,
    output logic [7:0] err_cnt
);

    localparam logic [BYTE_IDX_W-1:0] FRAME_LAST = BYTE_IDX_W'(FRAME_LEN);
    localparam logic [HIT_CNT_W-1:0]  LOCK_C     = HIT_CNT_W'(LOCK_CNT);
    localparam logic [MISS_CNT_W-1:0] LOSS_C     = MISS_CNT_W'(LOSS_CNT);

    logic                  accept_s;
    logic [7:0]            shreg_next_s;
    logic                  byte_done_s;
    logic                  align_s;
    logic                  sync_match_s;
    logic [BYTE_IDX_W-1:0] idx_adv_s;
    logic                  emit_s;
    logic                  sof_s;
    logic                  err_inc_s;

    state_t                state_r, state_nxt_s;
    logic [BYTE_IDX_W-1:0] byte_idx_r, byte_idx_nxt_s;
    logic [HIT_CNT_W-1:0]  hit_cnt_r, hit_cnt_nxt_s;
    logic [MISS_CNT_W-1:0] miss_cnt_r, miss_cnt_nxt_s;
    logic [7:0]            err_cnt_r;
    logic [7:0]            byte_out_r;
    logic                  byte_valid_r;
    logic                  byte_sof_r;
    logic                  locked_r;

    assign accept_s = ena && bit_valid;

    serdes_deser_shift u_shift (
        .clk        (clk),
        .rst_n      (rst_n),
        .shift_en   (accept_s),
        .align      (align_s),
        .bit_in     (bit_in),
        .shreg_next (shreg_next_s),
        .byte_done  (byte_done_s)
    );

    // Next-state, frame position, lock/loss counting and emit decisions.
    always_comb begin
        state_nxt_s    = state_r;
        byte_idx_nxt_s = byte_idx_r;
        hit_cnt_nxt_s  = hit_cnt_r;
        miss_cnt_nxt_s = miss_cnt_r;
        align_s        = 1'b0;
        emit_s         = 1'b0;
        sof_s          = 1'b0;
        err_inc_s      = 1'b0;
        idx_adv_s      = frame_idx_adv(byte_idx_r, FRAME_LAST);
        sync_match_s   = (shreg_next_s == SYNC_WORD);
        if (accept_s) begin
            case (state_r)
                ST_HUNT: begin
                    if (sync_match_s) begin
                        align_s        = 1'b1;
                        byte_idx_nxt_s = 4'd0;
                        hit_cnt_nxt_s  = 3'd1;
                        miss_cnt_nxt_s = 3'd0;
                        state_nxt_s    = (LOCK_C == 3'd1) ? ST_LOCKED : ST_VERIFY;
                    end else begin
                        state_nxt_s = ST_HUNT;
                    end
                end
                ST_VERIFY: begin
                    if (!byte_done_s) begin
                        state_nxt_s = ST_VERIFY;
                    end else if (idx_adv_s != 4'd0) begin
                        byte_idx_nxt_s = idx_adv_s;
                    end else if (sync_match_s) begin
                        byte_idx_nxt_s = idx_adv_s;
                        hit_cnt_nxt_s  = hit_cnt_r + 3'd1;
                        state_nxt_s    = (hit_cnt_nxt_s == LOCK_C) ? ST_LOCKED : ST_VERIFY;
                    end else begin
                        byte_idx_nxt_s = idx_adv_s;
                        hit_cnt_nxt_s  = 3'd0;
                        state_nxt_s    = ST_HUNT;
                    end
                end
                ST_LOCKED: begin
                    if (!byte_done_s) begin
                        state_nxt_s = ST_LOCKED;
                    end else if (idx_adv_s != 4'd0) begin
                        byte_idx_nxt_s = idx_adv_s;
                        emit_s         = 1'b1;
                        sof_s          = (idx_adv_s == 4'd1);
                    end else if (sync_match_s) begin
                        byte_idx_nxt_s = idx_adv_s;
                        miss_cnt_nxt_s = 3'd0;
                    end else begin
                        // Flywheel: keep alignment until enough sync slots in a row are bad.
                        byte_idx_nxt_s = idx_adv_s;
                        err_inc_s      = 1'b1;
                        miss_cnt_nxt_s = miss_cnt_r + 3'd1;
                        if (miss_cnt_nxt_s == LOSS_C) begin
                            miss_cnt_nxt_s = 3'd0;
                            hit_cnt_nxt_s  = 3'd0;
                            state_nxt_s    = ST_HUNT;
                        end else begin
                            state_nxt_s = ST_LOCKED;
                        end
                    end
                end
                default: begin
                    state_nxt_s    = ST_HUNT;
                    hit_cnt_nxt_s  = 3'd0;
                    miss_cnt_nxt_s = 3'd0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // FSM state and frame/lock/loss counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_HUNT;
            byte_idx_r <= 4'd0;
            hit_cnt_r  <= 3'd0;
            miss_cnt_r <= 3'd0;
        end else begin
            state_r    <= state_nxt_s;
            byte_idx_r <= byte_idx_nxt_s;
            hit_cnt_r  <= hit_cnt_nxt_s;
            miss_cnt_r <= miss_cnt_nxt_s;
        end
    end

    // Saturating error counter; a clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_r <= 8'd0;
        end else if (ena && clear_err) begin
            err_cnt_r <= 8'd0;
        end else if (err_inc_s && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'd1;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    // Registered byte interface and lock flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_out_r   <= 8'd0;
            byte_valid_r <= 1'b0;
            byte_sof_r   <= 1'b0;
            locked_r     <= 1'b0;
        end else begin
            byte_out_r   <= emit_s ? shreg_next_s : byte_out_r;
            byte_valid_r <= emit_s;
            byte_sof_r   <= emit_s && sof_s;
            locked_r     <= (state_nxt_s == ST_LOCKED);
        end
    end

    assign byte_out   = byte_out_r;
    assign byte_valid = byte_valid_r;
    assign byte_sof   = byte_sof_r;
    assign locked     = locked_r;
    assign state      = state_r;
    assign err_cnt    = err_cnt_r;

endmodule

// File: tb/tb_serdes_sync_ctrl.sv
// Bench for serdes_sync_ctrl: frame-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_serdes_sync_ctrl;

    localparam int FRAME_LEN = 4;
    localparam int LOCK_CNT  = 3;
    localparam int LOSS_CNT  = 4;
    localparam int SYNC      = 'hA5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       clear_err = 1'b0;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_sof;
    logic       locked;
    logic [1:0] state;
    logic [7:0] err_cnt;

    int total = 0;
    int bad = 0;
    bit gap_en = 1'b0;

    // reference model: mode 0/1/2 = hunt/verify/locked
    int m_mode = 0, m_win = 0, m_nbits = 0, m_good = 0, m_bad = 0, m_err = 0;
    int exp_valid = 0, exp_sof = 0, exp_byte = 0;
    int mlog[$];

    serdes_sync_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .clear_err  (clear_err),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_sof   (byte_sof),
        .locked     (locked),
        .state      (state),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_win = 0; m_nbits = 0; m_good = 0; m_bad = 0; m_err = 0;
        exp_valid = 0; exp_sof = 0; exp_byte = 0;
    endtask

    // One clock of the link as described at frame level: bits since alignment give the slot.
    task automatic model_step();
        int slot;
        bit match, inc;
        inc = 1'b0;
        exp_valid = 0;
        exp_sof = 0;
        if (ena && bit_valid) begin
            m_win = ((m_win << 1) | int'(bit_in)) & 255;
            match = (m_win == SYNC);
            if (m_mode == 0) begin
                if (match) begin
                    m_mode = (LOCK_CNT == 1) ? 2 : 1;
                    m_good = 1; m_bad = 0; m_nbits = 0;
                end
            end else begin
                m_nbits++;
                if (m_nbits % 8 == 0) begin
                    slot = (m_nbits / 8) % (FRAME_LEN + 1);
                    if (slot != 0) begin
                        if (m_mode == 2) begin
                            exp_valid = 1; exp_sof = (slot == 1); exp_byte = m_win;
                            mlog.push_back(m_win);
                        end
                    end else if (m_mode == 1) begin
                        if (match) begin
                            m_good++;
                            if (m_good == LOCK_CNT) m_mode = 2;
                        end else begin
                            m_mode = 0; m_good = 0;
                        end
                    end else if (match) begin
                        m_bad = 0;
                    end else begin
                        m_bad++; inc = 1'b1;
                        if (m_bad == LOSS_CNT) begin
                            m_mode = 0; m_bad = 0; m_good = 0;
                        end
                    end
                end
            end
        end
        if (inc && m_err < 255) m_err++;
        if (ena && clear_err) m_err = 0;
    endtask

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        check("byte_valid", int'(byte_valid), exp_valid);
        check("byte_sof", int'(byte_sof), exp_sof);
        check("byte_out", int'(byte_out), exp_byte);
        check("state", int'(state), m_mode);
        check("locked", int'(locked), int'(m_mode == 2));
        check("err_cnt", int'(err_cnt), m_err);
    end

    task automatic bit1(input logic b, input logic clr);
        int n;
        n = 0;
        if (gap_en && $urandom_range(0, 2) == 0) n = $urandom_range(1, 4);
        repeat (n) begin
            ena = 1'($urandom_range(0, 1));
            bit_valid = ena ? 1'b0 : 1'($urandom_range(0, 1));
            bit_in = 1'($urandom_range(0, 1));
            clear_err = 1'b0;
            @(posedge clk); #1;
        end
        ena = 1'b1; bit_valid = 1'b1; bit_in = b; clear_err = clr;
        @(posedge clk); #1;
        bit_valid = 1'b0; clear_err = 1'b0;
    endtask

    task automatic byte8(input logic [7:0] v, input logic clr);
        for (int i = 7; i >= 0; i--) bit1(v[i], (i == 0) ? clr : 1'b0);
    endtask

    task automatic frame(input logic [7:0] s, input logic [7:0] base);
        logic [7:0] p;
        byte8(s, 1'b0);
        for (int i = 0; i < FRAME_LEN; i++) begin
            p = base + 8'(8'h11 * i);
            byte8(p, 1'b0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_byte_out"}, int'(byte_out), 0);
        check({tag, "_byte_valid"}, int'(byte_valid), 0);
        check({tag, "_byte_sof"}, int'(byte_sof), 0);
        check({tag, "_locked"}, int'(locked), 0);
        check({tag, "_state"}, int'(state), 0);
        check({tag, "_err_cnt"}, int'(err_cnt), 0);
    endtask

    initial begin
        int n0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Acquisition: junk, then three sync frames lock on the third sync byte.
        repeat (5) bit1(1'b0, 1'b0);
        frame(8'hA5, 8'h11);
        frame(8'hA5, 8'h11);
        check("acq_state_verify", int'(state), 1);
        byte8(8'hA5, 1'b0);
        check("acq_locked_edge", int'(locked), 1);
        check("acq_nothing_early", mlog.size(), 0);
        for (int i = 0; i < FRAME_LEN; i++) byte8(8'(8'h11 * (i + 1)), 1'b0);
        frame(8'hA5, 8'h11);
        check("acq_emit_count", mlog.size(), 8);
        check("acq_first_byte", mlog[0], 'h11);
        check("acq_last_byte", mlog[7], 'h44);

        // Flywheel: three bad syncs keep lock, the fourth drops it.
        frame(8'h5A, 8'h01);
        frame(8'h5A, 8'h01);
        frame(8'h5A, 8'h01);
        check("fly_locked", int'(locked), 1);
        check("fly_err3", int'(err_cnt), 3);
        check("fly_emitted", mlog.size(), 20);
        byte8(8'h5A, 1'b0);
        check("loss_state", int'(state), 0);
        check("loss_locked", int'(locked), 0);
        check("loss_err4", int'(err_cnt), 4);

        // VERIFY reject: one good sync, then a corrupt sync slot.
        n0 = mlog.size();
        frame(8'hA5, 8'h11);
        check("rej_state_verify", int'(state), 1);
        byte8(8'h5A, 1'b0);
        check("rej_state_hunt", int'(state), 0);
        check("rej_no_emit", mlog.size(), n0);
        frame(8'hA5, 8'h11);
        frame(8'hA5, 8'h11);
        frame(8'hA5, 8'h11);
        frame(8'hA5, 8'h55);
        check("relock", int'(locked), 1);
        check("relock_emit", mlog.size(), n0 + 8);

        // Saturation: runs of three bad syncs then a good one.
        while (m_err < 255) begin
            frame(8'h5A, 8'h21);
            frame(8'h5A, 8'h21);
            frame(8'h5A, 8'h21);
            frame(8'hA5, 8'h21);
        end
        check("sat_255", int'(err_cnt), 255);
        check("sat_locked", int'(locked), 1);
        byte8(8'h3C, 1'b0);
        check("sat_hold", int'(err_cnt), 255);
        for (int i = 0; i < FRAME_LEN; i++) byte8(8'h77, 1'b0);
        byte8(8'h3C, 1'b1);
        check("clear_wins", int'(err_cnt), 0);
        for (int i = 0; i < FRAME_LEN; i++) byte8(8'h99, 1'b0);
        frame(8'hA5, 8'h10);

        // Gaps, mid-byte async reset, then gapped reacquisition.
        gap_en = 1'b1;
        frame(8'hA5, 8'h12);
        for (int i = 0; i < 4; i++) bit1(1'b1, 1'b0);
        check("pre_reset_locked", int'(locked), 1);
        rst_n = 1'b0;
        #2;
        check_reset_outputs("async_reset");
        ena = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n0 = mlog.size();
        repeat (5) bit1(1'b0, 1'b0);
        frame(8'hA5, 8'h11);
        frame(8'hA5, 8'h11);
        frame(8'hA5, 8'h11);
        frame(8'hA5, 8'h55);
        check("gap_emit_count", mlog.size(), n0 + 8);
        check("gap_byte0", mlog[n0], 'h11);
        check("gap_byte4", mlog[n0 + 4], 'h55);
        check("gap_byte7", mlog[n0 + 7], 'h88);
        gap_en = 1'b0;
        ena = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
